// File: rtl/dspl_frame_capture_if.sv
// Frame readback bus for dspl_frame_capture.
//   frame_digits  32  digit i at [4i+3:4i]
//   frame_blank    8  bit i = digit i had all segments off
//   frame_dp       8  bit i = dp of digit i lit
//   frame_segerr   8  bit i = digit i pattern not decodable (nibble reads 4'hF)
//   frame_valid    1  complete frame held on the bus
//   frame_ready    1  consumer takes the frame when frame_valid & frame_ready
// master = frame producer (capture block), slave = consumer.
interface dspl_frame_capture_if;
    logic [31:0] frame_digits;
    logic [7:0]  frame_blank;
    logic [7:0]  frame_dp;
    logic [7:0]  frame_segerr;
    logic        frame_valid;
    logic        frame_ready;

    modport master (
        output frame_digits, frame_blank, frame_dp, frame_segerr, frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_digits, frame_blank, frame_dp, frame_segerr, frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/dspl_frame_capture.sv
// Receiving end of a multiplexed 7-segment display bus. Samples the anode
// scan and segment bus, accepts a digit once {an,dec_ddp} has been stable for
// STABLE_CYC cycles, decodes it back to hex and assembles 8-digit frames that
// are offered on a valid/ready handshake.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-low
//   an         in   anode select, active-low (an[i]=0 selects digit i)
//   dec_ddp    in   [7:1]={a..g} segments, [0]=dp, active-low
//   clr_flags  in   one-cycle pulse clearing the sticky overrun flag
//   frame      if   frame readback bus (master side)
//   an_err     out  one-cycle pulse: settled an neither one-hot-low nor 8'hFF
//   overrun    out  sticky: frame completed while the previous one was unaccepted
module dspl_frame_capture #(
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  an,
    input  logic [7:0]                  dec_ddp,
    input  logic                        clr_flags,
    dspl_frame_capture_if.master        frame,
    output logic                        an_err,
    output logic                        overrun
);
    localparam int unsigned SW = $clog2(STABLE_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t        state, state_nxt;
    logic [7:0]    an_q, ddp_q, an_p, ddp_p;
    logic [SW-1:0] stab;
    logic [TW-1:0] tcnt;
    logic [7:0]    mask;
    logic [31:0]   stage_digits;
    logic [7:0]    stage_blank, stage_dp, stage_segerr;
    logic          change, accept, bad_an;
    logic [2:0]    idx;
    logic [5:0]    dec;

    // Returns {blank, segerr, nibble} for an active-high abcdefg pattern.
    function automatic logic [5:0] decode(input logic [6:0] seg);
        logic [5:0] r;
        case (seg)
            7'h7E:   r = {2'b00, 4'h0};
            7'h30:   r = {2'b00, 4'h1};
            7'h6D:   r = {2'b00, 4'h2};
            7'h79:   r = {2'b00, 4'h3};
            7'h33:   r = {2'b00, 4'h4};
            7'h5B:   r = {2'b00, 4'h5};
            7'h5F:   r = {2'b00, 4'h6};
            7'h70:   r = {2'b00, 4'h7};
            7'h7F:   r = {2'b00, 4'h8};
            7'h7B:   r = {2'b00, 4'h9};
            7'h77:   r = {2'b00, 4'hA};
            7'h1F:   r = {2'b00, 4'hB};
            7'h4E:   r = {2'b00, 4'hC};
            7'h3D:   r = {2'b00, 4'hD};
            7'h4F:   r = {2'b00, 4'hE};
            7'h47:   r = {2'b00, 4'hF};
            7'h00:   r = {2'b10, 4'h0};
            default: r = {2'b01, 4'hF};
        endcase
        return r;
    endfunction

    assign change = {an_q, ddp_q} != {an_p, ddp_p};
    assign dec    = decode(~ddp_q[7:1]);

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!an_q[i]) idx = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        bad_an    = 1'b0;
        case (state)
            IDLE:   if (change) state_nxt = SETTLE;
            SETTLE: begin
                if (!change && stab == SW'(STABLE_CYC)) begin
                    state_nxt = HOLD;
                    if ($onehot(~an_q))   accept = 1'b1;
                    else if (an_q != '1)  bad_an = 1'b1;
                end
            end
            HOLD:   if (change) state_nxt = SETTLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Input sampling and stability counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= '0;
            ddp_q <= '0;
            an_p  <= '0;
            ddp_p <= '0;
            stab  <= '0;
        end else begin
            an_q  <= an;
            ddp_q <= dec_ddp;
            an_p  <= an_q;
            ddp_p <= ddp_q;
            if (change)                     stab <= SW'(1);
            else if (stab != SW'(STABLE_CYC)) stab <= stab + SW'(1);
        end
    end

    // Staging, capture mask, timeout, frame handshake and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask               <= '0;
            tcnt               <= '0;
            stage_digits       <= '0;
            stage_blank        <= '0;
            stage_dp           <= '0;
            stage_segerr       <= '0;
            frame.frame_digits <= '0;
            frame.frame_blank  <= '0;
            frame.frame_dp     <= '0;
            frame.frame_segerr <= '0;
            frame.frame_valid  <= 1'b0;
            an_err             <= 1'b0;
            overrun            <= 1'b0;
        end else begin
            an_err <= bad_an;

            if (accept) begin
                stage_digits[{idx, 2'b00} +: 4] <= dec[3:0];
                stage_blank[idx]                <= dec[5];
                stage_segerr[idx]               <= dec[4];
                stage_dp[idx]                   <= ~ddp_q[0];
                mask[idx]                       <= 1'b1;
                tcnt                            <= '0;
            end else if (mask == '1) begin
                mask <= '0;
                tcnt <= '0;
            end else if (mask != '0) begin
                if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    mask <= '0;
                    tcnt <= '0;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end else begin
                tcnt <= '0;
            end

            // A completed frame loads when the output slot is free or being
            // consumed this cycle; otherwise it is dropped and flagged.
            if (mask == '1 && (!frame.frame_valid || frame.frame_ready)) begin
                frame.frame_digits <= stage_digits;
                frame.frame_blank  <= stage_blank;
                frame.frame_dp     <= stage_dp;
                frame.frame_segerr <= stage_segerr;
                frame.frame_valid  <= 1'b1;
            end else if (frame.frame_valid && frame.frame_ready) begin
                frame.frame_valid  <= 1'b0;
            end

            if (mask == '1 && frame.frame_valid && !frame.frame_ready) overrun <= 1'b1;
            else if (clr_flags)                                         overrun <= 1'b0;
        end
    end
endmodule
